fetch_aligner: RTL and testbench

Instruction-fetch front end for the compressed-capable pipeline. It issues word-aligned fetches to instruction memory and buffers the returned halfwords. It presents one aligned instruction per handshake, either 16-bit compressed or 32-bit, together with its PC. It also produces the 2-bit PC-increment select that the 4:1 next-PC multiplexer consumes: 00 selects PC+4, 01 selects PC+2, 10 selects the redirect target.

---
 rtl/fetch_aligner_pkg.sv | 20 ++
 rtl/fetch_aligner_halfword_queue.sv | 51 +++++
 rtl/fetch_aligner.sv | 125 ++++++++++++
 tb/tb_fetch_aligner.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_aligner_pkg.sv
// Shared definitions for the instruction-fetch aligner: next-PC select codes,
// fetch FSM state encodings and the compressed-instruction test.
package fetch_aligner_pkg;

    localparam logic [1:0] PCSEL_PLUS4 = 2'b00;
    localparam logic [1:0] PCSEL_PLUS2 = 2'b01;
    localparam logic [1:0] PCSEL_REDIR = 2'b10;

    typedef logic [1:0] state_t;

    localparam state_t ST_FETCH = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_KILL  = 2'd2;

    // Any low-bit pattern other than 2'b11 marks a 16-bit instruction.
    function automatic logic is_compressed(input logic [15:0] halfword);
        return halfword[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_aligner_halfword_queue.sv
// Four-entry circular buffer of 16-bit halfwords. Accepts a full word or only
// its upper half, and releases one or two halfwords from the head per cycle.
module halfword_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push2,
    input  logic        push_hi,
    input  logic [31:0] wdata,
    input  logic        pop1,
    input  logic        pop2,
    output logic [15:0] entry0,
    output logic [15:0] entry1,
    output logic [2:0]  count
);

    logic [15:0] slots [4];
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [2:0]  push_n;
    logic [2:0]  pop_n;

    assign tail   = head + count[1:0];
    assign push_n = push2 ? 3'd2 : (push_hi ? 3'd1 : 3'd0);
    assign pop_n  = pop2 ? 3'd2 : (pop1 ? 3'd1 : 3'd0);
    assign entry0 = slots[head];
    assign entry1 = slots[head + 2'd1];

    // Push and pop may coincide; the count nets the two. Flush wins over both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            count <= '0;
            for (int i = 0; i < 4; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (push2) begin
                slots[tail]        <= wdata[15:0];
                slots[tail + 2'd1] <= wdata[31:16];
            end else if (push_hi) begin
                slots[tail] <= wdata[31:16];
            end
            head  <= head + pop_n[1:0];
            count <= count + push_n - pop_n;
        end
    end

endmodule

// File: rtl/fetch_aligner.sv
// Instruction-fetch front end: word fetches into a halfword queue, presenting
// one aligned 16- or 32-bit instruction per handshake plus the next-PC select.
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_compressed,
    output logic [1:0]  pc_sel
);

    state_t      state;
    logic [31:0] fetch_addr;
    logic [31:0] head_pc;
    logic        drop_first;
    logic [15:0] entry0;
    logic [15:0] entry1;
    logic [2:0]  count;
    logic        head_comp;
    logic        accept;
    logic        push_any;
    logic        outstanding;
    logic [31:0] redirect_word;

    halfword_queue u_queue (
        .clk    (clk),
        .rst    (rst),
        .flush  (redirect),
        .push2  (push_any && !drop_first),
        .push_hi(push_any && drop_first),
        .wdata  (mem_rdata),
        .pop1   (accept && head_comp),
        .pop2   (accept && !head_comp),
        .entry0 (entry0),
        .entry1 (entry1),
        .count  (count)
    );

    assign head_comp     = is_compressed(entry0);
    assign inst_valid    = !redirect && (((count != 3'd0) && head_comp) ||
                                         ((count >= 3'd2) && !head_comp));
    assign inst_compressed = inst_valid && head_comp;
    assign inst_out      = !inst_valid ? 32'h0 :
                           head_comp   ? {16'h0, entry0} : {entry1, entry0};
    assign inst_pc       = head_pc;
    assign accept        = inst_valid && inst_ready;
    assign push_any      = (state == ST_WAIT) && mem_valid && !redirect;
    assign outstanding   = ((state == ST_WAIT) || (state == ST_KILL)) && !mem_valid;
    assign redirect_word = {redirect_pc[31:2], 2'b00};

    always_comb begin
        pc_sel = PCSEL_PLUS4;
        if (redirect) begin
            pc_sel = PCSEL_REDIR;
        end else if (inst_valid && head_comp) begin
            pc_sel = PCSEL_PLUS2;
        end
    end

    // A redirect with nothing in flight issues its fetch at once, so the new
    // address reaches memory the cycle after the redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            fetch_addr <= {RESET_PC[31:2], 2'b00};
            head_pc    <= RESET_PC;
            drop_first <= RESET_PC[1];
            mem_req    <= 1'b0;
            mem_addr   <= {RESET_PC[31:2], 2'b00};
        end else begin
            mem_req <= 1'b0;
            if (redirect) begin
                head_pc    <= {redirect_pc[31:1], 1'b0};
                drop_first <= redirect_pc[1];
                fetch_addr <= redirect_word;
                if (outstanding) begin
                    state <= ST_KILL;
                end else begin
                    state    <= ST_WAIT;
                    mem_req  <= 1'b1;
                    mem_addr <= redirect_word;
                end
            end else begin
                if (accept) begin
                    head_pc <= head_pc + (head_comp ? 32'd2 : 32'd4);
                end
                case (state)
                    ST_FETCH: begin
                        if (count <= 3'd2) begin
                            mem_req  <= 1'b1;
                            mem_addr <= fetch_addr;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (mem_valid) begin
                            fetch_addr <= fetch_addr + 32'd4;
                            drop_first <= 1'b0;
                            state      <= ST_FETCH;
                        end
                    end
                    ST_KILL: begin
                        if (mem_valid) begin
                            state <= ST_FETCH;
                        end
                    end
                    default: state <= ST_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed scenarios followed by a
// randomized instruction stream checked against a program-image walk.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_compressed;
    logic [1:0]  pc_sel;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [15:0] hw [1024];
    logic [31:0] bounds [$];
    int          lat = 1;

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_valid      (mem_valid),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .inst_compressed(inst_compressed),
        .pc_sel         (pc_sel)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [9:0] idx;
        idx = {addr[10:2], 1'b0};
        return {hw[idx + 10'd1], hw[idx]};
    endfunction

    // Memory model: answers each request after 'lat' cycles; shares reset.
    logic        pending = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] req_addr = '0;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            pending   = 1'b0;
            mem_valid = 1'b0;
        end else begin
            mem_valid = 1'b0;
            if (pending) begin
                if (wait_cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_rdata = mem_word(req_addr);
                    pending   = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
            if (mem_req) begin
                check_output("single_outstanding", {31'h0, pending}, 32'h0);
                check_output("addr_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
                pending  = 1'b1;
                req_addr = mem_addr;
                wait_cnt = lat - 1;
            end
        end
    end

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (!mem_req && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check_output({tag, "_req_seen"}, {31'h0, mem_req}, 32'h1);
    endtask

    task automatic wait_inst(input string tag);
        int n = 0;
        while (!inst_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check_output({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
    endtask

    task automatic expect_inst(input string tag, input logic [31:0] pc,
                               input logic [31:0] inst, input logic comp,
                               input logic [1:0] sel);
        wait_inst(tag);
        check_output({tag, "_pc"}, inst_pc, pc);
        check_output({tag, "_inst"}, inst_out, inst);
        check_output({tag, "_comp"}, {31'h0, inst_compressed}, {31'h0, comp});
        check_output({tag, "_pcsel"}, {30'h0, pc_sel}, {30'h0, sel});
        inst_ready = 1'b1;
        @(posedge clk); #1;
        inst_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        check_output({tag, "_mem_addr"}, mem_addr, 32'h0);
        check_output({tag, "_inst_valid"}, {31'h0, inst_valid}, 32'h0);
        check_output({tag, "_inst_out"}, inst_out, 32'h0);
        check_output({tag, "_inst_pc"}, inst_pc, 32'h0);
        check_output({tag, "_comp"}, {31'h0, inst_compressed}, 32'h0);
        check_output({tag, "_pcsel"}, {30'h0, pc_sel}, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [15:0] lo;
        logic [9:0]  idx;
        logic        exp_comp;
        int          accepted;
        int          since_redir;
        int          cycles;
        int          p;

        // Program image: directed words, a compressed run, a random region.
        for (int i = 0; i < 1024; i++) hw[i] = 16'h0;
        hw[0] = 16'h0093; hw[1] = 16'h00A0;
        hw[2] = 16'h4501; hw[3] = 16'h4501;
        hw[4] = 16'h0001; hw[5] = 16'h0093;
        hw[6] = 16'h00A0; hw[7] = 16'h0000;
        for (int i = 128; i < 192; i++) hw[i] = {8'(i), 8'h01};
        p = 32'h400;
        while (p < 32'h7F0) begin
            if ($urandom_range(0, 1) == 1) begin
                lo = 16'($urandom);
                lo[1:0] = 2'($urandom_range(0, 2));
                hw[p >> 1] = lo;
                if (p < 32'h600) bounds.push_back(32'(p));
                p += 2;
            end else begin
                exp_inst = $urandom;
                exp_inst[1:0] = 2'b11;
                hw[p >> 1] = exp_inst[15:0];
                hw[(p >> 1) + 1] = exp_inst[31:16];
                if (p < 32'h600) bounds.push_back(32'(p));
                p += 4;
            end
        end

        // Reset values, first fetch timing and a 32-bit instruction.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("t1_first_req", {31'h0, mem_req}, 32'h1);
        check_output("t1_first_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        check_output("t1_not_yet_valid", {31'h0, inst_valid}, 32'h0);
        @(posedge clk); #1;
        check_output("t1_latency", {31'h0, inst_valid}, 32'h1);
        expect_inst("t1", 32'h0, 32'h00A00093, 1'b0, 2'b00);

        // Two compressed halves of one word.
        expect_inst("t2a", 32'h4, 32'h00004501, 1'b1, 2'b01);
        expect_inst("t2b", 32'h6, 32'h00004501, 1'b1, 2'b01);

        // 32-bit instruction straddling a word boundary.
        expect_inst("t3a", 32'h8, 32'h00000001, 1'b1, 2'b01);
        expect_inst("t3b", 32'hA, 32'h00A00093, 1'b0, 2'b00);

        // Redirect during WAIT with an odd-halfword target.
        lat = 4;
        redirect = 1'b1; redirect_pc = 32'h80;
        @(posedge clk); #1;
        redirect = 1'b0;
        wait_mem_req("t4_pre");
        check_output("t4_pre_addr", mem_addr, 32'h80);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h102;
        #1;
        check_output("t4_redir_pcsel", {30'h0, pc_sel}, 32'h2);
        check_output("t4_redir_invalid", {31'h0, inst_valid}, 32'h0);
        @(posedge clk); #1;
        redirect = 1'b0;
        lat = 1;
        wait_mem_req("t4_new");
        check_output("t4_new_addr", mem_addr, 32'h100);
        expect_inst("t4", 32'h102, 32'h00008101, 1'b1, 2'b01);

        // Backpressure on a compressed stream.
        wait_inst("t5_stall");
        for (int k = 0; k < 12; k++) begin
            check_output("t5_hold_valid", {31'h0, inst_valid}, 32'h1);
            check_output("t5_hold_pc", inst_pc, 32'h104);
            check_output("t5_hold_inst", inst_out, 32'h00008201);
            if (k >= 6) check_output("t5_full_no_req", {31'h0, mem_req}, 32'h0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 6; i++) begin
            expect_inst("t5_resume", 32'h104 + 32'(2 * i),
                        {16'h0, 8'(8'h82 + i), 8'h01}, 1'b1, 2'b01);
        end

        // Asynchronous reset while a request is outstanding.
        lat = 5;
        wait_mem_req("t6");
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        lat = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("t6_req", {31'h0, mem_req}, 32'h1);
        check_output("t6_addr", mem_addr, 32'h0);
        expect_inst("t6", 32'h0, 32'h00A00093, 1'b0, 2'b00);

        // Redirect from FETCH fetches the new address next cycle.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h401;
        #1;
        check_output("t7_pcsel", {30'h0, pc_sel}, 32'h2);
        @(posedge clk); #1;
        redirect = 1'b0;
        check_output("t7_req", {31'h0, mem_req}, 32'h1);
        check_output("t7_addr", mem_addr, 32'h400);

        // Random ready, latency and redirects against an image walk.
        exp_pc = 32'h400;
        accepted = 0;
        since_redir = 0;
        cycles = 0;
        while (accepted < 150 && cycles < 6000) begin
            cycles++;
            lat = $urandom_range(1, 3);
            if (since_redir >= 37) begin
                inst_ready = 1'b0;
                exp_pc = bounds[$urandom_range(0, bounds.size() - 1)];
                redirect = 1'b1;
                redirect_pc = exp_pc | 32'($urandom_range(0, 1));
                #1;
                check_output("rand_redir_pcsel", {30'h0, pc_sel}, 32'h2);
                check_output("rand_redir_invalid", {31'h0, inst_valid}, 32'h0);
                since_redir = 0;
                @(posedge clk); #1;
                redirect = 1'b0;
            end else begin
                inst_ready = 1'($urandom_range(0, 1));
                if (inst_valid && inst_ready) begin
                    idx = exp_pc[10:1];
                    lo = hw[idx];
                    exp_comp = (lo[1:0] != 2'b11);
                    exp_inst = exp_comp ? {16'h0, lo} : {hw[idx + 10'd1], lo};
                    check_output("rand_pc", inst_pc, exp_pc);
                    check_output("rand_inst", inst_out, exp_inst);
                    check_output("rand_comp", {31'h0, inst_compressed}, {31'h0, exp_comp});
                    check_output("rand_pcsel", {30'h0, pc_sel}, {31'h0, exp_comp});
                    exp_pc += exp_comp ? 32'd2 : 32'd4;
                    accepted++;
                    since_redir++;
                end
                @(posedge clk); #1;
            end
        end
        check_output("rand_progress", {31'h0, accepted >= 150}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
